frame_receiver: RTL and testbench

Serial frame receiver on the far end of the point-to-point link. Consumes the decoded bit stream (one bit per `i_bit_valid` strobe, LSB first) produced by the line decoder, acquires and holds lock on the periodic sync magic, parses start magic, 16-bit size and payload, and emits payload bytes with frame delimiters. `o_locked` is the local lock indication fed back to the link transmitter.

---
 rtl/frame_receiver.sv | 224 ++++++++++++++++++++++
 tb/tb_frame_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_receiver.sv
// rtl/frame_receiver.sv - serial frame receiver: sync lock, start/size parse, payload byte delivery
// Bits arrive LSB first; magic matching is done on the post-shift register value.
module frame_receiver #(
   parameter logic [31:0] SYNC_MAGIC     = 32'h0000_96C3,
   parameter logic [31:0] START_MAGIC    = 32'h0000_EA57,
   parameter logic [15:0] MAX_FRAME_SIZE = 16'd4096,
   parameter logic [19:0] LOCK_TIMEOUT   = 20'd200_000,
   parameter logic [19:0] BIT_TIMEOUT    = 20'd1_000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_bit,
   input  logic        i_bit_valid,
   input  logic        i_clear_status,
   output logic [7:0]  o_data,
   output logic        o_data_valid,
   output logic        o_frame_start,
   output logic        o_frame_end,
   output logic        o_frame_abort,
   output logic [15:0] o_frame_size,
   output logic [7:0]  o_frames_count,
   output logic        o_locked,
   output logic [15:0] o_status
);

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_SIZE_LO = 3'd2,
      ST_SIZE_HI = 3'd3,
      ST_DATA    = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] magic_sr_q, magic_sr_d;
   logic [7:0]  byte_sr_q, byte_sr_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [19:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]  size_lo_q, size_lo_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]  data_q, data_d;
   logic        data_valid_q, data_valid_d;
   logic        frame_start_q, frame_start_d;
   logic        frame_end_q, frame_end_d;
   logic        frame_abort_q, frame_abort_d;
   logic [15:0] frame_size_q, frame_size_d;
   logic [7:0]  frames_count_q, frames_count_d;
   logic        locked_q, locked_d;
   logic        err_abort_q, err_abort_d;
   logic        err_size_q, err_size_d;
   logic        lock_lost_q, lock_lost_d;
   logic        bad_state_q, bad_state_d;
   logic [15:0] status_q, status_d;

   logic [31:0] magic_shift;
   logic [7:0]  byte_shift;
   logic [15:0] size_rx;
   logic        byte_done;
   logic        in_frame_d;

   always_comb begin
      magic_shift    = {i_bit, magic_sr_q[31:1]};
      byte_shift     = {i_bit, byte_sr_q[7:1]};
      size_rx        = {byte_shift, size_lo_q};
      byte_done      = i_bit_valid && (bit_cnt_q == 3'd7);

      state_d        = state_q;
      magic_sr_d     = magic_sr_q;
      byte_sr_d      = byte_sr_q;
      bit_cnt_d      = bit_cnt_q;
      tmo_cnt_d      = tmo_cnt_q;
      size_lo_d      = size_lo_q;
      byte_cnt_d     = byte_cnt_q;
      data_d         = data_q;
      data_valid_d   = 1'b0;
      frame_start_d  = 1'b0;
      frame_end_d    = 1'b0;
      frame_abort_d  = 1'b0;
      frame_size_d   = frame_size_q;
      frames_count_d = frames_count_q;
      // Clear first so an error raised on the same edge wins.
      err_abort_d    = err_abort_q & ~i_clear_status;
      err_size_d     = err_size_q  & ~i_clear_status;
      lock_lost_d    = lock_lost_q & ~i_clear_status;
      bad_state_d    = bad_state_q & ~i_clear_status;

      if (i_bit_valid) begin
         magic_sr_d = magic_shift;
         byte_sr_d  = byte_shift;
         bit_cnt_d  = bit_cnt_q + 3'd1;
      end

      case (state_q)
         ST_HUNT: begin
            if (i_bit_valid && (magic_shift == SYNC_MAGIC)) begin
               state_d   = ST_IDLE;
               tmo_cnt_d = '0;
            end
         end
         ST_IDLE: begin
            if (i_bit_valid && (magic_shift == SYNC_MAGIC)) begin
               tmo_cnt_d = '0;
            end else if (i_bit_valid && (magic_shift == START_MAGIC)) begin
               state_d   = ST_SIZE_LO;
               bit_cnt_d = '0;
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q >= LOCK_TIMEOUT) begin
               state_d     = ST_HUNT;
               lock_lost_d = 1'b1;
               magic_sr_d  = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 20'd1;
            end
         end
         ST_SIZE_LO, ST_SIZE_HI, ST_DATA: begin
            if (i_bit_valid) begin
               tmo_cnt_d = '0;
               if (byte_done) begin
                  if (state_q == ST_SIZE_LO) begin
                     size_lo_d = byte_shift;
                     state_d   = ST_SIZE_HI;
                  end else if (state_q == ST_SIZE_HI) begin
                     if ((size_rx == 16'd0) || (size_rx > MAX_FRAME_SIZE)) begin
                        err_size_d    = 1'b1;
                        frame_abort_d = 1'b1;
                        state_d       = ST_IDLE;
                     end else begin
                        frame_size_d  = size_rx;
                        frame_start_d = 1'b1;
                        byte_cnt_d    = 16'd1;
                        state_d       = ST_DATA;
                     end
                  end else begin
                     data_d       = byte_shift;
                     data_valid_d = 1'b1;
                     if (byte_cnt_q == frame_size_q) begin
                        frame_end_d    = 1'b1;
                        frames_count_d = frames_count_q + 8'd1;
                        state_d        = ST_IDLE;
                        magic_sr_d     = '0;
                     end else begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                     end
                  end
               end
            end else if (tmo_cnt_q >= BIT_TIMEOUT) begin
               err_abort_d   = 1'b1;
               frame_abort_d = 1'b1;
               state_d       = ST_IDLE;
               tmo_cnt_d     = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 20'd1;
            end
         end
         default: begin
            state_d     = ST_HUNT;
            bad_state_d = 1'b1;
         end
      endcase

      locked_d   = (state_d != ST_HUNT);
      in_frame_d = (state_d == ST_SIZE_LO) || (state_d == ST_SIZE_HI) || (state_d == ST_DATA);
      status_d   = {locked_d, in_frame_d, (err_size_d | err_abort_d | lock_lost_d), 1'b0,
                    1'b0, state_d, 4'b0000,
                    err_abort_d, err_size_d, lock_lost_d, bad_state_d};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= ST_HUNT;
         magic_sr_q     <= '0;
         byte_sr_q      <= '0;
         bit_cnt_q      <= '0;
         tmo_cnt_q      <= '0;
         size_lo_q      <= '0;
         byte_cnt_q     <= '0;
         data_q         <= '0;
         data_valid_q   <= 1'b0;
         frame_start_q  <= 1'b0;
         frame_end_q    <= 1'b0;
         frame_abort_q  <= 1'b0;
         frame_size_q   <= '0;
         frames_count_q <= '0;
         locked_q       <= 1'b0;
         err_abort_q    <= 1'b0;
         err_size_q     <= 1'b0;
         lock_lost_q    <= 1'b0;
         bad_state_q    <= 1'b0;
         status_q       <= '0;
      end else begin
         state_q        <= state_d;
         magic_sr_q     <= magic_sr_d;
         byte_sr_q      <= byte_sr_d;
         bit_cnt_q      <= bit_cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
         size_lo_q      <= size_lo_d;
         byte_cnt_q     <= byte_cnt_d;
         data_q         <= data_d;
         data_valid_q   <= data_valid_d;
         frame_start_q  <= frame_start_d;
         frame_end_q    <= frame_end_d;
         frame_abort_q  <= frame_abort_d;
         frame_size_q   <= frame_size_d;
         frames_count_q <= frames_count_d;
         locked_q       <= locked_d;
         err_abort_q    <= err_abort_d;
         err_size_q     <= err_size_d;
         lock_lost_q    <= lock_lost_d;
         bad_state_q    <= bad_state_d;
         status_q       <= status_d;
      end
   end

   assign o_data         = data_q;
   assign o_data_valid   = data_valid_q;
   assign o_frame_start  = frame_start_q;
   assign o_frame_end    = frame_end_q;
   assign o_frame_abort  = frame_abort_q;
   assign o_frame_size   = frame_size_q;
   assign o_frames_count = frames_count_q;
   assign o_locked       = locked_q;
   assign o_status       = status_q;

endmodule

// File: tb/tb_frame_receiver.sv
// tb/tb_frame_receiver.sv - self-checking bench for frame_receiver
// Timeouts and max size are shrunk through parameters to keep runs short.
module tb_frame_receiver;

   localparam logic [31:0] SYNC  = 32'h0000_96C3;
   localparam logic [31:0] START = 32'h0000_EA57;
   localparam int LT = 300;
   localparam int BT = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bit_i = 1'b0;
   logic        bit_valid = 1'b0;
   logic        clear = 1'b0;
   logic [7:0]  o_data;
   logic        o_data_valid;
   logic        o_frame_start;
   logic        o_frame_end;
   logic        o_frame_abort;
   logic [15:0] o_frame_size;
   logic [7:0]  o_frames_count;
   logic        o_locked;
   logic [15:0] o_status;

   frame_receiver #(
      .MAX_FRAME_SIZE(16'd6),
      .LOCK_TIMEOUT  (20'd300),
      .BIT_TIMEOUT   (20'd40)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_bit         (bit_i),
      .i_bit_valid   (bit_valid),
      .i_clear_status(clear),
      .o_data        (o_data),
      .o_data_valid  (o_data_valid),
      .o_frame_start (o_frame_start),
      .o_frame_end   (o_frame_end),
      .o_frame_abort (o_frame_abort),
      .o_frame_size  (o_frame_size),
      .o_frames_count(o_frames_count),
      .o_locked      (o_locked),
      .o_status      (o_status)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int n_start = 0, n_end = 0, n_abort = 0, n_end_dv = 0;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (o_data_valid) rx_q.push_back(o_data);
      if (o_frame_start) n_start++;
      if (o_frame_end) n_end++;
      if (o_frame_end && o_data_valid) n_end_dv++;
      if (o_frame_abort) n_abort++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [15:0] size;
      int          nbytes;
      logic [47:0] pl;
      bit          exp_abort;
      logic [15:0] exp_status;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      bit_i = b;
      bit_valid = 1'b1;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bit_valid = 1'b0;
         bit_i = 1'b0;
      end
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      bit_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] size, input int nb, input logic [47:0] pl);
      send_bits(START, 32);
      send_bits({16'h0000, size}, 16);
      for (int i = 0; i < nb; i++) send_bits({24'h0, pl[8*i +: 8]}, 8);
   endtask

   initial begin
      vec_t tbl[6];
      logic [31:0] sync_w;
      int s0, e0, a0, d0, q0, exp_count, abort_at, lost_at;
      logic [15:0] exp_size;

      tbl[0] = '{16'd3, 3, 48'h0000_00FF_3CA5, 1'b0, 16'h8100};
      tbl[1] = '{16'd0, 0, 48'h0,              1'b1, 16'hA104};
      tbl[2] = '{16'd4, 4, 48'h0000_0000_EA57, 1'b0, 16'h8100};
      tbl[3] = '{16'd7, 0, 48'h0,              1'b1, 16'hA104};
      tbl[4] = '{16'd6, 6, 48'h8005_0403_0201, 1'b0, 16'h8100};
      tbl[5] = '{16'd1, 1, 48'h0000_0000_0081, 1'b0, 16'h8100};
      sync_w = SYNC;
      exp_count = 0;
      exp_size = '0;

      repeat (3) @(negedge clk);
      chk("reset_status", o_status, 16'h0000);
      chk("reset_locked", o_locked, 1'b0);
      chk("reset_size", o_frame_size, 16'h0);
      chk("reset_count", o_frames_count, 8'h0);
      chk("reset_data_pulses", {o_data, o_data_valid, o_frame_start, o_frame_end, o_frame_abort}, 12'h0);
      rst_n = 1'b1;

      // Lock acquisition: not locked after 31 bits, locked one cycle after bit 31.
      send_bits(sync_w, 31);
      @(negedge clk);
      chk("prelock_locked", o_locked, 1'b0);
      bit_i = sync_w[31];
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      chk("lock_locked", o_locked, 1'b1);
      chk("lock_status", o_status, 16'h8100);

      for (int t = 0; t < 6; t++) begin
         clear_pulse();
         chk($sformatf("v%0d_status_cleared", t), o_status, 16'h8100);
         s0 = n_start; e0 = n_end; a0 = n_abort; d0 = n_end_dv; q0 = rx_q.size();
         send_frame(tbl[t].size, tbl[t].nbytes, tbl[t].pl);
         idle(3);
         if (!tbl[t].exp_abort) begin
            exp_count++;
            exp_size = tbl[t].size;
         end
         chk($sformatf("v%0d_starts", t), n_start - s0, tbl[t].exp_abort ? 0 : 1);
         chk($sformatf("v%0d_ends", t), n_end - e0, tbl[t].exp_abort ? 0 : 1);
         chk($sformatf("v%0d_end_with_data", t), n_end_dv - d0, tbl[t].exp_abort ? 0 : 1);
         chk($sformatf("v%0d_aborts", t), n_abort - a0, tbl[t].exp_abort ? 1 : 0);
         chk($sformatf("v%0d_nbytes", t), rx_q.size() - q0, tbl[t].nbytes);
         for (int i = 0; i < tbl[t].nbytes; i++)
            chk($sformatf("v%0d_byte%0d", t, i), rx_q[q0 + i], tbl[t].pl[8*i +: 8]);
         chk($sformatf("v%0d_frame_size", t), o_frame_size, exp_size);
         chk($sformatf("v%0d_frames_count", t), o_frames_count, exp_count[7:0]);
         chk($sformatf("v%0d_status", t), o_status, tbl[t].exp_status);
      end

      // Back-to-back frames with no gap between last payload bit and next start magic.
      s0 = n_start; e0 = n_end; q0 = rx_q.size();
      send_frame(16'd2, 2, 48'h2211);
      send_frame(16'd1, 1, 48'h33);
      idle(3);
      exp_count += 2;
      chk("b2b_starts", n_start - s0, 2);
      chk("b2b_ends", n_end - e0, 2);
      chk("b2b_nbytes", rx_q.size() - q0, 3);
      chk("b2b_bytes", {rx_q[q0], rx_q[q0+1], rx_q[q0+2]}, 24'h112233);
      chk("b2b_count", o_frames_count, exp_count[7:0]);
      chk("b2b_size", o_frame_size, 16'd1);

      // Bit timeout after 2 of 5 payload bytes.
      clear_pulse();
      s0 = n_start; e0 = n_end; a0 = n_abort; q0 = rx_q.size();
      send_frame(16'd5, 2, 48'hC35A);
      abort_at = 0;
      for (int i = 1; i <= BT + 10; i++) begin
         @(negedge clk);
         bit_valid = 1'b0;
         if (o_frame_abort && abort_at == 0) abort_at = i;
      end
      chk("bittmo_latency_in_range", (abort_at >= BT + 1) && (abort_at <= BT + 3), 1'b1);
      chk("bittmo_aborts", n_abort - a0, 1);
      chk("bittmo_ends", n_end - e0, 0);
      chk("bittmo_nbytes", rx_q.size() - q0, 2);
      chk("bittmo_status", o_status, 16'hA108);
      chk("bittmo_locked", o_locked, 1'b1);
      chk("bittmo_count", o_frames_count, exp_count[7:0]);

      // Lock timeout measured from a sync match.
      clear_pulse();
      send_bits(SYNC, 32);
      lost_at = 0;
      for (int i = 1; i <= LT + 20; i++) begin
         @(negedge clk);
         bit_valid = 1'b0;
         if (!o_locked && lost_at == 0) lost_at = i;
      end
      chk("locktmo_latency_in_range", (lost_at >= LT + 1) && (lost_at <= LT + 3), 1'b1);
      chk("locktmo_status", o_status, 16'h2002);
      send_bits(START, 32);
      idle(3);
      chk("start_no_relock", o_locked, 1'b0);
      chk("start_no_relock_status", o_status, 16'h2002);
      send_bits(SYNC, 32);
      idle(1);
      chk("sync_relock", o_locked, 1'b1);
      chk("sync_relock_status", o_status, 16'hA102);

      // Asynchronous reset in the middle of a frame.
      clear_pulse();
      a0 = n_abort;
      send_frame(16'd4, 1, 48'h11);
      send_bits(32'h5, 3);
      #2;
      rst_n = 1'b0;
      bit_valid = 1'b0;
      #1;
      chk("midrst_status", o_status, 16'h0000);
      chk("midrst_locked", o_locked, 1'b0);
      chk("midrst_size", o_frame_size, 16'h0);
      chk("midrst_count", o_frames_count, 8'h0);
      chk("midrst_data_pulses", {o_data, o_data_valid, o_frame_start, o_frame_end, o_frame_abort}, 12'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      chk("postrst_status", o_status, 16'h0000);
      chk("postrst_no_abort", n_abort - a0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
